// File: rtl/uart_rx_if.sv
// Receive-side byte channel from uart_rx to its consumer: byte, qualifying
// status flags, line-activity indication and the consumer's ready.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  // valid_o/ready_i: a byte transfers in any cycle where both are high;
  // data_o and parity_err_o hold steady while valid_o is high and not accepted.
  logic [DATA_BITS-1:0] data_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 parity_err_o;
  logic                 frame_err_o;
  logic                 overrun_o;
  logic                 busy_o;

  modport master (
    output data_o,
    output valid_o,
    output parity_err_o,
    output frame_err_o,
    output overrun_o,
    output busy_o,
    input  ready_i
  );

  modport slave (
    input  data_o,
    input  valid_o,
    input  parity_err_o,
    input  frame_err_o,
    input  overrun_o,
    input  busy_o,
    output ready_i
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx_i, samples each bit at its centre, checks
// optional parity and the stop bit, and hands bytes out over valid/ready.
module uart_rx #(
  parameter int BR_CNT_MAX  = 867,
  parameter int BR2_CNT_MAX = BR_CNT_MAX / 2,
  parameter int DATA_BITS   = 8,
  parameter bit PARITY_EN   = 1'b0,
  parameter bit PARITY_ODD  = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  uart_rx_if.master  bus,
  output logic [2:0] state_o
);

  localparam int CW = (BR_CNT_MAX > 0) ? $clog2(BR_CNT_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(BR_CNT_MAX);
  localparam logic [CW-1:0] CNT_HALF = CW'(BR2_CNT_MAX);
  localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta, rx_s;
  logic [CW-1:0]        cnt_q;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q;
  logic                 at_bit_end;
  logic                 shift_en;
  logic                 par_load;
  logic                 deliver;
  logic                 frame_bad;

  // Both synchroniser flops reset to the idle line level so reset never
  // looks like a start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  assign at_bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    par_load  = 1'b0;
    deliver   = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) state_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (at_bit_end) begin
          shift_en = 1'b1;
          if (bit_idx_q == LAST_IDX) state_d = PARITY_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (at_bit_end) begin
          par_load = 1'b1;
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (at_bit_end) begin
          if (rx_s) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_bad = 1'b1;
            state_d   = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Clearing on every state change keeps all later samples one full bit
  // period apart, starting from the start-bit centre.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if ((state_d != state_q) || at_bit_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
    end else begin
      if (state_q != S_DATA) begin
        bit_idx_q <= '0;
      end else if (shift_en) begin
        bit_idx_q <= bit_idx_q + 1'b1;
      end
      if (shift_en) shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
      if (state_q == S_START) begin
        par_err_q <= 1'b0;
      end else if (par_load) begin
        par_err_q <= (^shift_q) ^ rx_s ^ PARITY_ODD;
      end
    end
  end

  // A new byte may replace the held one only when that one is being taken in
  // the same cycle; otherwise the new byte is lost and flagged as overrun.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.data_o       <= '0;
      bus.valid_o      <= 1'b0;
      bus.parity_err_o <= 1'b0;
      bus.frame_err_o  <= 1'b0;
      bus.overrun_o    <= 1'b0;
    end else begin
      bus.frame_err_o <= frame_bad;
      bus.overrun_o   <= 1'b0;
      if (deliver) begin
        if (!bus.valid_o || bus.ready_i) begin
          bus.data_o       <= shift_q;
          bus.parity_err_o <= par_err_q;
          bus.valid_o      <= 1'b1;
        end else begin
          bus.overrun_o <= 1'b1;
        end
      end else if (bus.valid_o && bus.ready_i) begin
        bus.valid_o <= 1'b0;
      end
    end
  end

  assign bus.busy_o = (state_q != S_IDLE);
  assign state_o    = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 instance and an 8E1 instance at a 16-clock bit
// period, with a byte scoreboard fed by the stimulus tasks.
module tb_uart_rx;

  localparam int BIT_CLKS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b;
  logic [2:0] state_a, state_b;

  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(8)) bus_a ();
  uart_rx_if #(.DATA_BITS(8)) bus_b ();

  uart_rx #(
    .BR_CNT_MAX(15), .BR2_CNT_MAX(7), .DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .rx_i(rx_a), .bus(bus_a.master), .state_o(state_a)
  );

  uart_rx #(
    .BR_CNT_MAX(15), .BR2_CNT_MAX(7), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .rx_i(rx_b), .bus(bus_b.master), .state_o(state_b)
  );

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];   // {parity_err, data}

  int valid_cyc_a = 0, ferr_a = 0, ovr_a = 0;
  int valid_cyc_b = 0, ferr_b = 0, ovr_b = 0;
  logic [8:0] mon_exp_a, mon_exp_b;

  // Scoreboard: every accepted byte must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.valid_o)     valid_cyc_a++;
      if (bus_a.frame_err_o) ferr_a++;
      if (bus_a.overrun_o)   ovr_a++;
      if (bus_a.valid_o && bus_a.ready_i) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_a got=%h want=none", {bus_a.parity_err_o, bus_a.data_o});
        end else begin
          mon_exp_a = exp_q.pop_front();
          if ({bus_a.parity_err_o, bus_a.data_o} !== mon_exp_a) begin
            bad++;
            $display("FAIL sb_byte_a got=%h want=%h", {bus_a.parity_err_o, bus_a.data_o}, mon_exp_a);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_b.valid_o)     valid_cyc_b++;
      if (bus_b.frame_err_o) ferr_b++;
      if (bus_b.overrun_o)   ovr_b++;
      if (bus_b.valid_o && bus_b.ready_i) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_b got=%h want=none", {bus_b.parity_err_o, bus_b.data_o});
        end else begin
          mon_exp_b = exp_q.pop_front();
          if ({bus_b.parity_err_o, bus_b.data_o} !== mon_exp_b) begin
            bad++;
            $display("FAIL sb_byte_b got=%h want=%h", {bus_b.parity_err_o, bus_b.data_o}, mon_exp_b);
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // bits[0] goes on the line first; each bit is held for one bit period.
  task automatic drive_bits(input logic [15:0] bits, input int n, input bit on_b);
    for (int i = 0; i < n; i++) begin
      if (on_b) rx_b = bits[i];
      else      rx_a = bits[i];
      tick(BIT_CLKS);
    end
  endtask

  task automatic wait_empty(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) tick(1);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    bus_a.ready_i = 1'b1; bus_b.ready_i = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus_a.valid_o, bus_a.parity_err_o, bus_a.frame_err_o, bus_a.overrun_o, bus_a.busy_o} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags_a got=%b want=00000",
               {bus_a.valid_o, bus_a.parity_err_o, bus_a.frame_err_o, bus_a.overrun_o, bus_a.busy_o});
    end
    total++;
    if (bus_a.data_o !== 8'h00) begin
      bad++; $display("FAIL reset_data_a got=%h want=00", bus_a.data_o);
    end
    total++;
    if ({bus_b.valid_o, bus_b.parity_err_o, bus_b.frame_err_o, bus_b.overrun_o, bus_b.busy_o, bus_b.data_o} !== 13'b0) begin
      bad++; $display("FAIL reset_b got=%h want=0",
                      {bus_b.valid_o, bus_b.parity_err_o, bus_b.frame_err_o, bus_b.overrun_o, bus_b.busy_o, bus_b.data_o});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tick(4);
    total++;
    if (bus_a.busy_o !== 1'b0 || state_a !== 3'd0) begin
      bad++; $display("FAIL post_reset_idle got=%b/%0d want=0/0", bus_a.busy_o, state_a);
    end
  endtask

  task automatic test_basic_8n1;
    int v0, f0, o0;
    v0 = valid_cyc_a; f0 = ferr_a; o0 = ovr_a;
    exp_q.push_back({1'b0, 8'hA5});
    drive_bits(16'({1'b1, 8'hA5, 1'b0}), 10, 1'b0);
    wait_empty(40);
    tick(4);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL basic_delivered got=%0d want=0 pending", exp_q.size());
    end
    total++;
    if (valid_cyc_a - v0 != 1) begin
      bad++; $display("FAIL basic_valid_cycles got=%0d want=1", valid_cyc_a - v0);
    end
    total++;
    if (ferr_a - f0 != 0 || ovr_a - o0 != 0) begin
      bad++; $display("FAIL basic_err_pulses got=%0d/%0d want=0/0", ferr_a - f0, ovr_a - o0);
    end
    total++;
    if (bus_a.busy_o !== 1'b0) begin
      bad++; $display("FAIL basic_busy_after got=%b want=0", bus_a.busy_o);
    end
  endtask

  task automatic test_glitch;
    int v0, f0, o0, waited;
    v0 = valid_cyc_a; f0 = ferr_a; o0 = ovr_a;
    rx_a = 1'b0;
    tick(4);
    total++;
    if (bus_a.busy_o !== 1'b1) begin
      bad++; $display("FAIL glitch_busy_seen got=%b want=1", bus_a.busy_o);
    end
    rx_a = 1'b1;
    waited = 0;
    while (bus_a.busy_o === 1'b1 && waited < 12) begin
      tick(1);
      waited++;
    end
    total++;
    if (bus_a.busy_o !== 1'b0) begin
      bad++; $display("FAIL glitch_busy_clear got=%b want=0", bus_a.busy_o);
    end
    tick(4);
    total++;
    if (valid_cyc_a - v0 != 0 || ferr_a - f0 != 0 || ovr_a - o0 != 0) begin
      bad++; $display("FAIL glitch_no_output got=%0d/%0d/%0d want=0/0/0",
                      valid_cyc_a - v0, ferr_a - f0, ovr_a - o0);
    end
  endtask

  task automatic test_frame_error;
    int v0, f0, waited;
    v0 = valid_cyc_a; f0 = ferr_a;
    drive_bits(16'({1'b0, 8'h3C, 1'b0}), 10, 1'b0);
    tick(40);
    total++;
    if (bus_a.busy_o !== 1'b1) begin
      bad++; $display("FAIL break_busy_held got=%b want=1", bus_a.busy_o);
    end
    total++;
    if (ferr_a - f0 != 1) begin
      bad++; $display("FAIL frame_err_pulses got=%0d want=1", ferr_a - f0);
    end
    rx_a = 1'b1;
    waited = 0;
    while (bus_a.busy_o === 1'b1 && waited < 8) begin
      tick(1);
      waited++;
    end
    total++;
    if (bus_a.busy_o !== 1'b0) begin
      bad++; $display("FAIL break_release got=%b want=0", bus_a.busy_o);
    end
    tick(20);
    total++;
    if (valid_cyc_a - v0 != 0 || ferr_a - f0 != 1) begin
      bad++; $display("FAIL frame_err_no_byte got=%0d/%0d want=0/1", valid_cyc_a - v0, ferr_a - f0);
    end
  endtask

  task automatic test_back_to_back_overrun;
    int o0;
    o0 = ovr_a;
    bus_a.ready_i = 1'b0;
    exp_q.push_back({1'b0, 8'h11});
    drive_bits(16'({1'b1, 8'h11, 1'b0}), 10, 1'b0);
    drive_bits(16'({1'b1, 8'h22, 1'b0}), 10, 1'b0);
    tick(4);
    total++;
    if (ovr_a - o0 != 1) begin
      bad++; $display("FAIL overrun_pulses got=%0d want=1", ovr_a - o0);
    end
    total++;
    if (bus_a.valid_o !== 1'b1 || bus_a.data_o !== 8'h11) begin
      bad++; $display("FAIL overrun_hold got=%b/%h want=1/11", bus_a.valid_o, bus_a.data_o);
    end
    bus_a.ready_i = 1'b1;
    tick(2);
    total++;
    if (bus_a.valid_o !== 1'b0) begin
      bad++; $display("FAIL overrun_consume got=%b want=0", bus_a.valid_o);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL overrun_delivered got=%0d want=0 pending", exp_q.size());
    end
  endtask

  task automatic test_parity;
    int f0, o0;
    f0 = ferr_b; o0 = ovr_b;
    // 0x03 has even weight, so even parity expects a 0 parity bit.
    exp_q.push_back({1'b1, 8'h03});
    drive_bits(16'({1'b1, 1'b1, 8'h03, 1'b0}), 11, 1'b1);
    exp_q.push_back({1'b0, 8'h03});
    drive_bits(16'({1'b1, 1'b0, 8'h03, 1'b0}), 11, 1'b1);
    wait_empty(40);
    tick(4);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL parity_delivered got=%0d want=0 pending", exp_q.size());
    end
    total++;
    if (ferr_b - f0 != 0 || ovr_b - o0 != 0 || bus_b.busy_o !== 1'b0) begin
      bad++; $display("FAIL parity_side_flags got=%0d/%0d/%b want=0/0/0", ferr_b - f0, ovr_b - o0, bus_b.busy_o);
    end
  endtask

  task automatic test_reset_mid_frame;
    int v0, f0, o0;
    logic [7:0] d;
    d = 8'h5A;
    drive_bits(16'({d[2:0], 1'b0}), 4, 1'b0);
    rx_a = d[3];
    tick(8);
    rst = 1'b1;
    rx_a = 1'b1;
    tick(3);
    total++;
    if ({bus_a.valid_o, bus_a.busy_o, bus_a.frame_err_o, bus_a.overrun_o} !== 4'b0) begin
      bad++; $display("FAIL midreset_flags got=%b want=0000",
                      {bus_a.valid_o, bus_a.busy_o, bus_a.frame_err_o, bus_a.overrun_o});
    end
    rst = 1'b0;
    v0 = valid_cyc_a; f0 = ferr_a; o0 = ovr_a;
    tick(20);
    total++;
    if (valid_cyc_a - v0 != 0 || bus_a.busy_o !== 1'b0) begin
      bad++; $display("FAIL midreset_quiet got=%0d/%b want=0/0", valid_cyc_a - v0, bus_a.busy_o);
    end
    exp_q.push_back({1'b0, d});
    drive_bits(16'({1'b1, d, 1'b0}), 10, 1'b0);
    wait_empty(40);
    tick(4);
    total++;
    if (exp_q.size() != 0 || valid_cyc_a - v0 != 1) begin
      bad++; $display("FAIL midreset_next_byte got=%0d/%0d want=0/1", exp_q.size(), valid_cyc_a - v0);
    end
    total++;
    if (ferr_a - f0 != 0 || ovr_a - o0 != 0) begin
      bad++; $display("FAIL midreset_err_pulses got=%0d/%0d want=0/0", ferr_a - f0, ovr_a - o0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_glitch();
    test_frame_error();
    test_back_to_back_overrun();
    test_parity();
    test_reset_mid_frame();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL final_queue got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
